// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Compares two WIDTH-bit operands CHUNK bits per clock, starting at the most
// significant chunk. It stops at the first chunk that differs, so the
// latency depends on the data. Operands can be unsigned or two's-complement.
//
// Ports
//   clk         : clock. All state changes on the rising edge.
//   rst_n       : asynchronous reset, active low.
//   start       : request a comparison. It is only accepted in IDLE.
//   signed_mode : 1 = two's-complement operands, 0 = unsigned.
//   x, y        : operands A and B. They are sampled on the accepting edge.
//   busy        : high while the FSM is not in IDLE.
//   done        : one-cycle pulse when the result becomes valid.
//   igual       : x == y
//   menor       : x <  y
//   maior       : x >  y
//   The result flags stay valid until the next accepted start.
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             igual,
   output logic             menor,
   output logic             maior
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPARE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   generate
      if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
         $error("WIDTH must be a positive integer multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_signed;
   logic             r_igual;
   logic             r_menor;
   logic             r_maior;

   logic [WIDTH-1:0] w_msb_flip;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [31:0]      w_shamt;
   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic             w_last;

   // Inverting the sign bit of both operands maps two's-complement order
   // onto unsigned order. The sign bit exists only in the top chunk, so
   // every lower chunk still compares as plain unsigned.
   assign w_msb_flip = {r_signed, {(WIDTH-1){1'b0}}};
   assign w_a        = r_x ^ w_msb_flip;
   assign w_b        = r_y ^ w_msb_flip;

   // Shift the current chunk down to bit 0 instead of using a variable
   // part-select.
   assign w_shamt    = 32'(r_idx) * 32'(CHUNK);
   assign w_a_sh     = w_a >> w_shamt;
   assign w_b_sh     = w_b >> w_shamt;
   assign w_a_chunk  = w_a_sh[CHUNK-1:0];
   assign w_b_chunk  = w_b_sh[CHUNK-1:0];
   assign w_last     = (r_idx == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_signed <= 1'b0;
         r_igual  <= 1'b0;
         r_menor  <= 1'b0;
         r_maior  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x      <= x;
                  r_y      <= y;
                  r_signed <= signed_mode;
                  r_idx    <= IDX_W'(N - 1);
                  r_igual  <= 1'b0;
                  r_menor  <= 1'b0;
                  r_maior  <= 1'b0;
                  r_state  <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (w_a_chunk > w_b_chunk) begin
                  r_maior <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_a_chunk < w_b_chunk) begin
                  r_menor <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_last) begin
                  r_igual <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx - 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_DONE);
   assign igual = r_igual;
   assign menor = r_menor;
   assign maior = r_maior;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int N     = WIDTH / CHUNK;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic             igual;
   logic             menor;
   logic             maior;

   int n_tests = 0;
   int n_fail  = 0;

   seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .x           (x),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .igual       (igual),
      .menor       (menor),
      .maior       (maior)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: compare the whole values arithmetically, and take the
   // latency from where the first differing chunk sits.
   function automatic logic [2:0] model_rel(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic s);
      logic lt, gt;
      if (s) begin
         lt = ($signed(a) < $signed(b));
         gt = ($signed(a) > $signed(b));
      end else begin
         lt = (a < b);
         gt = (a > b);
      end
      return {(a == b), lt, gt};   // {igual, menor, maior}
   endfunction

   function automatic int model_lat(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
      for (int i = 0; i < N; i++) begin
         if (a[(N-1-i)*CHUNK +: CHUNK] != b[(N-1-i)*CHUNK +: CHUNK])
            return i + 1;
      end
      return N;
   endfunction

   // One full transaction: start, wait for done, then check the result and
   // the return to IDLE.
   task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input string tag);
      int lat;
      int exp_lat;
      logic [2:0] exp_rel;
      exp_lat = model_lat(a, b);
      exp_rel = model_rel(a, b, s);
      @(negedge clk);
      x = a; y = b; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if ({busy, done, igual, menor, maior} !== 5'b10000) begin
         n_fail++;
         $display("FAIL %s accept: busy/done/flags=%b required 10000", tag, {busy, done, igual, menor, maior});
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (done !== 1'b1 && lat < 20);
      n_tests++;
      if (lat !== exp_lat || done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges (done=%b) required %0d", tag, lat, done, exp_lat);
      end
      n_tests++;
      if ({igual, menor, maior} !== exp_rel) begin
         n_fail++;
         $display("FAIL %s result: a=%h b=%h s=%b igual/menor/maior=%b required %b", tag, a, b, s, {igual, menor, maior}, exp_rel);
      end
      // Change the inputs while in IDLE without starting: the flags must hold.
      x = ~a; y = b ^ 16'h5A5A;
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, igual, menor, maior} !== {2'b00, exp_rel}) begin
         n_fail++;
         $display("FAIL %s after_done: busy/done/flags=%b required %b", tag, {busy, done, igual, menor, maior}, {2'b00, exp_rel});
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
      #3;
      n_tests++;
      if ({busy, done, igual, menor, maior} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_state: outputs=%b required 00000", {busy, done, igual, menor, maior});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, igual, menor, maior} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_release: outputs=%b required 00000", {busy, done, igual, menor, maior});
      end
   endtask

   task automatic test_directed;
      do_cmp(16'hA5A5, 16'hA5A5, 1'b0, "equal");
      do_cmp(16'h8000, 16'h7FFF, 1'b0, "early_unsigned");
      do_cmp(16'h8000, 16'h7FFF, 1'b1, "early_signed");
      do_cmp(16'h1234, 16'h1235, 1'b0, "last_chunk_unsigned");
      do_cmp(16'hFFFF, 16'hFFFE, 1'b1, "last_chunk_signed");
      do_cmp(16'h0000, 16'hFFFF, 1'b1, "zero_vs_minus1");
      do_cmp(16'h7FFF, 16'h8000, 1'b1, "max_vs_min_signed");
   endtask

   task automatic test_random;
      logic [WIDTH-1:0] a, b;
      int k;
      for (int i = 0; i < 60; i++) begin
         a = WIDTH'($urandom);
         b = a;
         // Disturb one chunk, or none, so that every latency occurs.
         k = int'($urandom_range(0, N));
         if (k < N) b[k*CHUNK +: CHUNK] = CHUNK'($urandom);
         if (i % 7 == 0) b = WIDTH'($urandom);
         do_cmp(a, b, 1'($urandom), "random");
      end
   endtask

   task automatic test_busy_protect;
      int lat;
      @(negedge clk);
      x = 16'hA5A5; y = 16'hA5A5; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      do begin
         // Pulse start with new operands while the first comparison runs.
         @(negedge clk);
         start = 1'b1; x = 16'h0001; y = 16'hF000; signed_mode = 1'b1;
         @(posedge clk); #1;
         lat++;
         if (done !== 1'b1) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_protect busy: got %b required 1 at edge %0d", busy, lat);
            end
         end
      end while (done !== 1'b1 && lat < 20);
      start = 1'b0;
      n_tests++;
      if (lat !== 4 || {busy, igual, menor, maior} !== 4'b1100) begin
         n_fail++;
         $display("FAIL busy_protect result: lat=%0d busy/flags=%b required lat=4 1100", lat, {busy, igual, menor, maior});
      end
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_protect exit: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      x = 16'hA5A5; y = 16'hA5A5; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, igual, menor, maior} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid outputs: got %b required 00000", {busy, done, igual, menor, maior});
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid hold: done=%b busy=%b required 0 0", done, busy);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_cmp(16'h1234, 16'h0234, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] ca, cb, na, nb;
      int lat;
      ca = 16'h1234; cb = 16'h1235;
      @(negedge clk);
      x = ca; y = cb; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < 6; j++) begin
         if (j % 2 == 0) begin na = 16'hC000 | WIDTH'($urandom_range(0, 255)); nb = 16'h4000; end
         else            begin na = 16'h1234; nb = 16'h1235; end
         x = na; y = nb;
         lat = 0;
         do begin
            @(posedge clk); #1;
            lat++;
         end while (done !== 1'b1 && lat < 20);
         n_tests++;
         if (lat !== model_lat(ca, cb) || {igual, menor, maior} !== model_rel(ca, cb, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b[%0d] result: lat=%0d flags=%b required lat=%0d flags=%b", j, lat, {igual, menor, maior}, model_lat(ca, cb), model_rel(ca, cb, 1'b0));
         end
         @(posedge clk); #1;
         n_tests++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b[%0d] idle_gap: busy=%b done=%b required 0 0", j, busy, done);
         end
         if (j == 5) start = 1'b0;
         @(posedge clk); #1;
         n_tests++;
         if (busy !== (j != 5) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b[%0d] accept: busy=%b done=%b required %b 0", j, busy, done, (j != 5));
         end
         ca = na; cb = nb;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_protect();
      test_reset_mid_op();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, giving the bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin a comparison.
REQ-006 The module SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-007 The module SHALL have port x, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port y, input, WIDTH bits: operand B.
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-011 The module SHALL have port igual, output, 1 bit: high when x == y.
REQ-012 The module SHALL have port menor, output, 1 bit: high when x < y.
REQ-013 The module SHALL have port maior, output, 1 bit: high when x > y.

Function
REQ-014 The FSM SHALL have three states: IDLE, COMPARE and DONE.
REQ-015 In IDLE, start=1 SHALL be accepted at a rising edge; that edge SHALL:
- latch x, y and signed_mode into internal registers;
- load the chunk index with N-1;
- clear igual, menor and maior;
- move the FSM to COMPARE.
REQ-016 start SHALL be ignored in COMPARE and DONE, and input changes after acceptance SHALL NOT affect the result.
REQ-017 Each COMPARE cycle SHALL compare the latched chunk [idx*CHUNK +: CHUNK] of both operands, MSB chunk first.
REQ-018 In signed mode, the operand MSB (bit WIDTH-1) SHALL be inverted on both operands before the top-chunk compare; all other chunks SHALL compare unsigned.
REQ-019 If the chunks differ, the FSM SHALL:
- set maior (A chunk > B chunk) or menor (A chunk < B chunk);
- move to DONE immediately, terminating early.
REQ-020 If the chunks are equal and idx == 0, the FSM SHALL set igual and move to DONE.
REQ-021 If the chunks are equal and idx > 0, the FSM SHALL decrement idx and stay in COMPARE.
REQ-022 Latency SHALL be k+1 rising edges from the accepting edge to done high, where k is the 0-based position of the first differing chunk counted from the MSB; equal operands SHALL take N edges.
REQ-023 done SHALL be high for exactly the one cycle the FSM spends in DONE, and DONE SHALL always return to IDLE at the next edge.
REQ-024 After done, exactly one of igual/menor/maior SHALL be 1 and SHALL be held until the next accepted start.
REQ-025 With start held high, a new comparison SHALL be accepted on the first edge in IDLE, one cycle after done.
REQ-026 When CHUNK == WIDTH (N = 1), every comparison SHALL complete in exactly 1 edge.

Reset
REQ-027 While rst_n = 0, asynchronously and regardless of clk:
- FSM SHALL be in IDLE;
- idx and the latched operands SHALL be 0;
- busy, done, igual, menor and maior SHALL be 0.
REQ-028 Reset asserted mid-COMPARE SHALL abort the comparison with no done pulse, and the first start after rst_n rises SHALL operate normally.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-029 The bench SHALL cover these directed scenarios:
- Equal: x=y=16'hA5A5, unsigned -> done 4 edges after start; igual=1, menor=0, maior=0.
- Early exit: x=16'h8000, y=16'h7FFF, unsigned -> done 1 edge after start, maior=1; same operands signed -> menor=1, also after 1 edge.
- Last-chunk difference: x=16'h1234, y=16'h1235 -> done after 4 edges, menor=1; signed x=16'hFFFF, y=16'hFFFE -> maior=1 after 4 edges.
- Busy protection: start pulsed again mid-COMPARE with new x/y -> ignored, result matches the first operands, busy stays high until DONE exits.
- Reset mid-operation: rst_n low during COMPARE -> all outputs 0 immediately, no done; new start after release gives the correct result.
- Back-to-back: start held high with alternating operands -> one done pulse per comparison, each result correct, one idle cycle between them.
